// File: rtl/encrypter_scheduler_if.sv
// -----------------------------------------------------------------------------
// encrypter_scheduler_if
// Bundle of the handshake/data signals between the scheduler and the shared
// Encrypter core.
//   enc_data_in / enc_rot_offset / enc_rdy_in : input-side word to the Encrypter
//   enc_req_in                                : Encrypter is ready to take it
//   enc_data_out / enc_req_out                : result word offered by the Encrypter
//   enc_rdy_out                               : scheduler can take the result
//   enc_prog                                  : registered enable, drives Encrypter prog
// Modports: master = scheduler side, slave = Encrypter side.
// -----------------------------------------------------------------------------
interface encrypter_scheduler_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ROT_WIDTH  = 4
);
    logic [DATA_WIDTH-1:0] enc_data_in;
    logic [ROT_WIDTH-1:0]  enc_rot_offset;
    logic                  enc_rdy_in;
    logic                  enc_req_in;
    logic [DATA_WIDTH-1:0] enc_data_out;
    logic                  enc_req_out;
    logic                  enc_rdy_out;
    logic                  enc_prog;

    modport master (
        output enc_data_in, enc_rot_offset, enc_rdy_in, enc_rdy_out, enc_prog,
        input  enc_req_in, enc_data_out, enc_req_out
    );

    modport slave (
        input  enc_data_in, enc_rot_offset, enc_rdy_in, enc_rdy_out, enc_prog,
        output enc_req_in, enc_data_out, enc_req_out
    );
endinterface

// File: rtl/encrypter_scheduler.sv
// -----------------------------------------------------------------------------
// encrypter_scheduler
// Round-robin scheduler sharing one Encrypter between NUM_CH requester channels.
// One transaction in flight at a time: grant -> input handshake -> output
// handshake -> result return to the owning channel.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   enable              permits new grants (also registered onto enc.enc_prog)
//   ch_valid/ch_data/ch_rot  per-channel request word and rotation offset
//   ch_ready            accept pulse to the granted channel while in SEND
//   res_valid/res_data/res_ready  one-hot result return to the owning channel
//   enc                 Encrypter bus (encrypter_scheduler_if.master)
//   busy                high whenever a transaction is in progress
//   grant_id            current or last granted channel
//   timeout_err         (ENC_SCHED_TIMEOUT_EN only) sticky WAIT_OUT watchdog flag
//
// Optional feature macro: ENC_SCHED_TIMEOUT_EN adds a WAIT_OUT watchdog that
// abandons the transaction after TIMEOUT_CYCLES cycles and sets timeout_err.
// -----------------------------------------------------------------------------
module encrypter_scheduler #(
    parameter int NUM_CH         = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int ROT_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [NUM_CH-1:0]              ch_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_data,
    input  logic [NUM_CH*ROT_WIDTH-1:0]    ch_rot,
    output logic [NUM_CH-1:0]              ch_ready,
    output logic [NUM_CH-1:0]              res_valid,
    output logic [DATA_WIDTH-1:0]          res_data,
    input  logic [NUM_CH-1:0]              res_ready,
    encrypter_scheduler_if.master          enc,
    output logic                           busy,
    output logic [$clog2(NUM_CH)-1:0]      grant_id
`ifdef ENC_SCHED_TIMEOUT_EN
    ,
    output logic                           timeout_err
`endif
);

    localparam int GW = $clog2(NUM_CH);

    // The watchdog counter is 8 bits wide, so the limit must fit in it.
    if (NUM_CH < 2 || NUM_CH > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
        $error("encrypter_scheduler: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_OUT = 2'd2,
        ST_RETURN   = 2'd3
    } state_t;

    state_t                 state_r, state_next_s;
    logic [GW-1:0]          grant_r, grant_next_s;
    logic [GW-1:0]          last_grant_r, last_grant_next_s;
    logic [DATA_WIDTH-1:0]  res_data_r, res_data_next_s;
    logic                   prog_r;

`ifdef ENC_SCHED_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]             wait_cnt_r, wait_cnt_next_s;
    logic                   timeout_err_r, timeout_err_next_s;
`endif

    // First requesting channel after 'last' in circular order; 'last' itself
    // is searched last so a lone requester can be re-granted.
    function automatic logic [GW-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                              input logic [GW-1:0]     last);
        logic [GW-1:0] pick;
        logic          found;
        int            idx;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = (int'(last) + i) % NUM_CH;
            if (!found && req[idx]) begin
                pick  = GW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // State register and per-transaction bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            grant_r      <= {GW{1'b0}};
            last_grant_r <= GW'(NUM_CH - 1);
            res_data_r   <= {DATA_WIDTH{1'b0}};
            prog_r       <= 1'b0;
`ifdef ENC_SCHED_TIMEOUT_EN
            wait_cnt_r    <= 8'd0;
            timeout_err_r <= 1'b0;
`endif
        end else begin
            state_r      <= state_next_s;
            grant_r      <= grant_next_s;
            last_grant_r <= last_grant_next_s;
            res_data_r   <= res_data_next_s;
            prog_r       <= enable;
`ifdef ENC_SCHED_TIMEOUT_EN
            wait_cnt_r    <= wait_cnt_next_s;
            timeout_err_r <= timeout_err_next_s;
`endif
        end
    end

    // Next-state and next-bookkeeping logic.
    always_comb begin
        state_next_s      = state_r;
        grant_next_s      = grant_r;
        last_grant_next_s = last_grant_r;
        res_data_next_s   = res_data_r;
`ifdef ENC_SCHED_TIMEOUT_EN
        wait_cnt_next_s    = wait_cnt_r;
        timeout_err_next_s = timeout_err_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (enable && (|ch_valid)) begin
                    grant_next_s = rr_pick(ch_valid, last_grant_r);
                    state_next_s = ST_SEND;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                // enc_rdy_in is high throughout SEND, so req alone completes the transfer.
                if (enc.enc_req_in) begin
                    state_next_s = ST_WAIT_OUT;
`ifdef ENC_SCHED_TIMEOUT_EN
                    wait_cnt_next_s = 8'd0;
`endif
                end else if (!ch_valid[grant_r]) begin
                    // Requester withdrew: abort without advancing the round-robin pointer.
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_SEND;
                end
            end
            ST_WAIT_OUT: begin
                if (enc.enc_req_out) begin
                    res_data_next_s = enc.enc_data_out;
                    state_next_s    = ST_RETURN;
                end
`ifdef ENC_SCHED_TIMEOUT_EN
                else if (wait_cnt_r == TO_LAST) begin
                    // This is the TIMEOUT_CYCLES-th cycle in WAIT_OUT: give up on the word.
                    state_next_s       = ST_IDLE;
                    last_grant_next_s  = grant_r;
                    timeout_err_next_s = 1'b1;
                end else begin
                    wait_cnt_next_s = wait_cnt_r + 8'd1;
                    state_next_s    = ST_WAIT_OUT;
                end
`else
                else begin
                    state_next_s = ST_WAIT_OUT;
                end
`endif
            end
            ST_RETURN: begin
                if (res_ready[grant_r]) begin
                    last_grant_next_s = grant_r;
                    state_next_s      = ST_IDLE;
                end else begin
                    state_next_s = ST_RETURN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output decode: Encrypter strobes, data mux and per-channel handshakes.
    always_comb begin
        enc.enc_rdy_in     = 1'b0;
        enc.enc_rdy_out    = 1'b0;
        enc.enc_data_in    = {DATA_WIDTH{1'b0}};
        enc.enc_rot_offset = {ROT_WIDTH{1'b0}};
        ch_ready           = {NUM_CH{1'b0}};
        res_valid          = {NUM_CH{1'b0}};
        case (state_r)
            ST_SEND: begin
                enc.enc_rdy_in        = 1'b1;
                enc.enc_data_in       = ch_data[int'(grant_r)*DATA_WIDTH +: DATA_WIDTH];
                enc.enc_rot_offset    = ch_rot[int'(grant_r)*ROT_WIDTH +: ROT_WIDTH];
                ch_ready[grant_r]     = enc.enc_req_in;
            end
            ST_WAIT_OUT: begin
                enc.enc_rdy_out = 1'b1;
            end
            ST_RETURN: begin
                res_valid[grant_r] = 1'b1;
            end
            default: begin
                enc.enc_rdy_in = 1'b0;
            end
        endcase
    end

    assign busy         = (state_r != ST_IDLE);
    assign res_data     = res_data_r;
    assign grant_id     = grant_r;
    assign enc.enc_prog = prog_r;
`ifdef ENC_SCHED_TIMEOUT_EN
    assign timeout_err  = timeout_err_r;
`endif

endmodule

// File: tb/tb_encrypter_scheduler.sv
// -----------------------------------------------------------------------------
// tb_encrypter_scheduler
// Directed, table-driven bench for encrypter_scheduler (NUM_CH=4, 16-bit data).
// The bench plays both the channel sources/sinks and the Encrypter.
// -----------------------------------------------------------------------------
module tb_encrypter_scheduler;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [3:0]  ch_valid;
    logic [63:0] ch_data;
    logic [15:0] ch_rot;
    logic [3:0]  ch_ready;
    logic [3:0]  res_valid;
    logic [15:0] res_data;
    logic [3:0]  res_ready;
    logic        busy;
    logic [1:0]  grant_id;
`ifdef ENC_SCHED_TIMEOUT_EN
    logic        timeout_err;
`endif

    int checks = 0;
    int errors = 0;

    encrypter_scheduler_if #(.DATA_WIDTH(16), .ROT_WIDTH(4)) enc_bus ();

    encrypter_scheduler #(
        .NUM_CH(4), .DATA_WIDTH(16), .ROT_WIDTH(4), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .ch_valid(ch_valid), .ch_data(ch_data), .ch_rot(ch_rot),
        .ch_ready(ch_ready), .res_valid(res_valid), .res_data(res_data),
        .res_ready(res_ready), .enc(enc_bus.master),
        .busy(busy), .grant_id(grant_id)
`ifdef ENC_SCHED_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic        reset_before;
        logic [3:0]  valid_before;
        logic [3:0]  valid_after;
        logic [1:0]  exp_grant;
        logic [15:0] exp_din;
        logic [3:0]  exp_rot;
        logic [15:0] ret_word;
        int          req_delay;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enc_bus.enc_req_in  = 1'b0;
        enc_bus.enc_req_out = 1'b0;
        res_ready = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One complete transaction; entered and left on a falling edge.
    task automatic do_txn(input logic [3:0] vb, input logic [3:0] va, input logic [1:0] g,
                          input logic [15:0] din, input logic [3:0] rot,
                          input logic [15:0] ret, input int delay);
        logic [3:0] oh;
        int n;
        oh = 4'b0001 << g;
        ch_valid = vb;
        n = 0;
        while (enc_bus.enc_rdy_in !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("grant_wait", (n < 20) ? 32'd1 : 32'd0, 32'd1);
        chk("grant_id", grant_id, g);
        chk("enc_data_in", enc_bus.enc_data_in, din);
        chk("enc_rot_offset", enc_bus.enc_rot_offset, rot);
        chk("ch_ready_idle", ch_ready, 4'b0000);
        for (int d = 0; d < delay; d++) begin
            @(negedge clk);
            chk("send_hold", {ch_ready, 3'b000, enc_bus.enc_rdy_in}, {4'b0000, 3'b000, 1'b1});
        end
        enc_bus.enc_req_in = 1'b1;
        #1;
        chk("ch_ready_pulse", ch_ready, oh);
        @(negedge clk);
        enc_bus.enc_req_in = 1'b0;
        ch_valid = va;
        chk("wait_out_strobes", {enc_bus.enc_rdy_out, enc_bus.enc_rdy_in}, 2'b10);
        chk("ch_ready_after", ch_ready, 4'b0000);
        enc_bus.enc_data_out = ret;
        enc_bus.enc_req_out  = 1'b1;
        @(negedge clk);
        enc_bus.enc_req_out = 1'b0;
        chk("res_valid", res_valid, oh);
        chk("res_data", res_data, ret);
        // res_ready on other channels must not release the result
        res_ready = ~oh;
        @(negedge clk);
        chk("res_hold", res_valid, oh);
        res_ready = oh;
        @(negedge clk);
        res_ready = 4'b0000;
        chk("done_busy", busy, 1'b0);
        chk("done_res_valid", res_valid, 4'b0000);
        chk("grant_hold", grant_id, g);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        enable = 1'b0;
        ch_valid = 4'b0000;
        ch_data = {16'h1234, 16'h5A5A, 16'hA5A5, 16'hCCE3};
        ch_rot  = {4'hF, 4'h2, 4'h1, 4'h7};
        res_ready = 4'b0000;
        enc_bus.enc_req_in   = 1'b0;
        enc_bus.enc_req_out  = 1'b0;
        enc_bus.enc_data_out = 16'h0000;

        vecs[0] = '{1'b1, 4'b0001, 4'b0000, 2'd0, 16'hCCE3, 4'h7, 16'hF0F0, 0};
        vecs[1] = '{1'b1, 4'b1111, 4'b1111, 2'd0, 16'hCCE3, 4'h7, 16'h0101, 0};
        vecs[2] = '{1'b0, 4'b1111, 4'b1111, 2'd1, 16'hA5A5, 4'h1, 16'h0202, 0};
        vecs[3] = '{1'b0, 4'b1111, 4'b1111, 2'd2, 16'h5A5A, 4'h2, 16'h0303, 5};
        vecs[4] = '{1'b0, 4'b1111, 4'b1111, 2'd3, 16'h1234, 4'hF, 16'h0404, 0};
        vecs[5] = '{1'b0, 4'b1111, 4'b1111, 2'd0, 16'hCCE3, 4'h7, 16'h0505, 0};
        vecs[6] = '{1'b0, 4'b1111, 4'b1111, 2'd1, 16'hA5A5, 4'h1, 16'h0606, 0};
        vecs[7] = '{1'b0, 4'b1111, 4'b1111, 2'd2, 16'h5A5A, 4'h2, 16'h0707, 0};
        vecs[8] = '{1'b0, 4'b1111, 4'b0000, 2'd3, 16'h1234, 4'hF, 16'h0808, 0};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_outputs", {res_valid, ch_ready, grant_id, enc_bus.enc_rdy_in,
                            enc_bus.enc_rdy_out, enc_bus.enc_prog}, 15'd0);
        chk("rst_res_data", res_data, 16'h0000);
        chk("rst_enc_data_in", enc_bus.enc_data_in, 16'h0000);
        reset = 1'b0;
        enable = 1'b1;

        // Table-driven transactions
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].reset_before) do_reset();
            do_txn(vecs[i].valid_before, vecs[i].valid_after, vecs[i].exp_grant,
                   vecs[i].exp_din, vecs[i].exp_rot, vecs[i].ret_word, vecs[i].req_delay);
        end

        // Reset during WAIT_OUT: pointer returns to NUM_CH-1
        do_reset();
        do_txn(4'b0001, 4'b0000, 2'd0, 16'hCCE3, 4'h7, 16'hAAAA, 0);
        ch_valid = 4'b0011;
        @(negedge clk);
        chk("pre_rst_grant", {enc_bus.enc_rdy_in, 1'b0, grant_id}, {1'b1, 1'b0, 2'd1});
        enc_bus.enc_req_in = 1'b1;
        @(negedge clk);
        enc_bus.enc_req_in = 1'b0;
        @(negedge clk);
        chk("pre_rst_wait_out", enc_bus.enc_rdy_out, 1'b1);
        reset = 1'b1;
        #1;
        chk("async_rst", {busy, enc_bus.enc_rdy_out, res_valid, grant_id}, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        do_txn(4'b0011, 4'b0000, 2'd0, 16'hCCE3, 4'h7, 16'h5555, 0);

        // enable low blocks grants; enc_prog follows enable one edge later
        do_reset();
        enable = 1'b0;
        ch_valid = 4'b0010;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (busy !== 1'b0) n++;
        end
        chk("disabled_no_grant", n, 0);
        chk("prog_low", enc_bus.enc_prog, 1'b0);
        enable = 1'b1;
        @(negedge clk);
        chk("enable_grant", {busy, 1'b0, grant_id}, {1'b1, 1'b0, 2'd1});
        chk("prog_high", enc_bus.enc_prog, 1'b1);
        do_txn(4'b0010, 4'b0000, 2'd1, 16'hA5A5, 4'h1, 16'h7E57, 0);

        // Abort in SEND keeps the pointer at the previous owner (channel 1)
        ch_valid = 4'b0100;
        @(negedge clk);
        chk("abort_grant", {enc_bus.enc_rdy_in, 1'b0, grant_id}, {1'b1, 1'b0, 2'd2});
        ch_valid = 4'b0000;
        @(negedge clk);
        chk("abort_idle", busy, 1'b0);
        do_txn(4'b1100, 4'b0000, 2'd2, 16'h5A5A, 4'h2, 16'h0BAD, 0);

`ifdef ENC_SCHED_TIMEOUT_EN
        // Watchdog: 64 WAIT_OUT cycles, then IDLE with sticky timeout_err
        do_reset();
        chk("to_err_reset", timeout_err, 1'b0);
        ch_valid = 4'b0001;
        @(negedge clk);
        enc_bus.enc_req_in = 1'b1;
        @(negedge clk);
        enc_bus.enc_req_in = 1'b0;
        ch_valid = 4'b0011;
        n = 0;
        while (enc_bus.enc_rdy_out === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("to_wait_cycles", n, 64);
        chk("to_err", timeout_err, 1'b1);
        chk("to_no_result", res_valid, 4'b0000);
        @(negedge clk);
        chk("to_next_grant", {enc_bus.enc_rdy_in, 1'b0, grant_id}, {1'b1, 1'b0, 2'd1});
        do_txn(4'b0011, 4'b0000, 2'd1, 16'hA5A5, 4'h1, 16'h1357, 0);
        chk("to_err_sticky", timeout_err, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
